// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
//
// Boot-time sequencer that owns the system-ID slave. After reset it reads the
// ID word (address 0) and the build timestamp (address 1), compares them with
// the build-time expected values and reports pass/fail. If the words do not
// match it retries the whole sequence, up to MAX_RETRY attempts in total.
// Once the check has finished, the sysid slave is shared with a host port,
// and host reads are serialized onto it one at a time.
//
// Build option:
//   SYSID_TIMESTAMP_CHECK_EN  defined   -> pass needs ID and timestamp to match
//                             undefined -> pass needs only the ID to match
//                                          (the timestamp is still read and captured)
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   sysid_address/read    word select and one-cycle read strobe to the sysid slave
//   sysid_readdata        sysid read data, sampled READ_LATENCY cycles after the strobe
//   host_address/read     host word select and read request (held while stalled)
//   host_waitrequest      host stall; low only while a host read can be accepted
//   host_readdata/valid   host read data with a one-cycle valid strobe
//   check_done/pass       boot check finished / words matched
//   id_word, ts_word      words captured by the most recent boot attempt
//   retry_count           boot attempts consumed
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BOOT_ID   | issue the read strobe for the ID word
// WAIT_ID   | count down the read latency, capture the ID word
// BOOT_TS   | issue the read strobe for the timestamp word
// WAIT_TS   | count down the read latency, capture the timestamp word
// CHECK     | compare the words, count the attempt, retry or finish
// READY     | check passed; host reads accepted here
// HOST_WAIT | host read in flight; capture and return data
// FAIL      | check failed (terminal); host reads still accepted here

module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523548286,
   parameter int unsigned READ_LATENCY       = 1,
   parameter int unsigned MAX_RETRY          = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   input  logic        host_address,
   input  logic        host_read,
   output logic        host_waitrequest,
   output logic [31:0] host_readdata,
   output logic        host_readdatavalid,
   output logic        check_done,
   output logic        check_pass,
   output logic [31:0] id_word,
   output logic [31:0] ts_word,
   output logic [3:0]  retry_count
);

   localparam logic [2:0] LAT   = 3'(READ_LATENCY);
   localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

`ifdef SYSID_TIMESTAMP_CHECK_EN
   localparam logic TS_CHECK = 1'b1;
`else
   localparam logic TS_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {
      BOOT_ID,
      WAIT_ID,
      BOOT_TS,
      WAIT_TS,
      CHECK,
      READY,
      HOST_WAIT,
      FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        wait_q, wait_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;

   logic        rd_strobe;
   logic        rd_addr;
   logic        id_match;
   logic        ts_match;
   logic        words_ok;

   assign id_match = (id_q == EXPECTED_ID);
   assign ts_match = (ts_q == EXPECTED_TIMESTAMP);
   // Without the timestamp check the timestamp compare is simply ignored.
   assign words_ok = id_match && (ts_match || !TS_CHECK);

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      retry_d   = retry_q;
      id_d      = id_q;
      ts_d      = ts_q;
      done_d    = done_q;
      pass_d    = pass_q;
      wait_d    = wait_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      rd_strobe = 1'b0;
      rd_addr   = 1'b0;

      unique case (state_q)
         BOOT_ID: begin
            rd_strobe = 1'b1;
            lat_cnt_d = LAT;
            state_d   = WAIT_ID;
         end
         // The strobe cycle loaded the counter; data is sampled when it hits 1.
         WAIT_ID: begin
            if (lat_cnt_q == 3'd1) begin
               id_d      = sysid_readdata;
               lat_cnt_d = 3'd0;
               state_d   = BOOT_TS;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         BOOT_TS: begin
            rd_strobe = 1'b1;
            rd_addr   = 1'b1;
            lat_cnt_d = LAT;
            state_d   = WAIT_TS;
         end
         WAIT_TS: begin
            if (lat_cnt_q == 3'd1) begin
               ts_d      = sysid_readdata;
               lat_cnt_d = 3'd0;
               state_d   = CHECK;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         CHECK: begin
            retry_d = retry_q + 4'd1;
            if (words_ok) begin
               pass_d  = 1'b1;
               done_d  = 1'b1;
               wait_d  = 1'b0;
               state_d = READY;
            end else if (retry_d >= MAX_R) begin
               pass_d  = 1'b0;
               done_d  = 1'b1;
               wait_d  = 1'b0;
               state_d = FAIL;
            end else begin
               state_d = BOOT_ID;
            end
         end
         // waitrequest is low in both of these states, so a host read seen
         // here is accepted this cycle and goes straight out to the slave.
         READY, FAIL: begin
            if (host_read) begin
               rd_strobe = 1'b1;
               rd_addr   = host_address;
               lat_cnt_d = LAT;
               wait_d    = 1'b1;
               state_d   = HOST_WAIT;
            end
         end
         HOST_WAIT: begin
            if (lat_cnt_q == 3'd1) begin
               rdata_d   = sysid_readdata;
               rvalid_d  = 1'b1;
               wait_d    = 1'b0;
               lat_cnt_d = 3'd0;
               state_d   = pass_q ? READY : FAIL;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = BOOT_ID;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= BOOT_ID;
         lat_cnt_q <= 3'd0;
         retry_q   <= 4'd0;
         id_q      <= 32'd0;
         ts_q      <= 32'd0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         wait_q    <= 1'b1;
         rdata_q   <= 32'd0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         retry_q   <= retry_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         wait_q    <= wait_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // The FSM sits in BOOT_ID during reset, which would otherwise strobe the
   // slave; masking with reset_n keeps the bus quiet until release, and the
   // first ID read goes out in the very first cycle after release.
   assign sysid_read    = rd_strobe & reset_n;
   assign sysid_address = rd_addr & reset_n;

   assign host_waitrequest   = wait_q;
   assign host_readdata      = rdata_q;
   assign host_readdatavalid = rvalid_q;
   assign check_done         = done_q;
   assign check_pass         = pass_q;
   assign id_word            = id_q;
   assign ts_word            = ts_q;
   assign retry_count        = retry_q;

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM master/sequencer that owns the system-ID slave (address 0 = ID word, address 1 = build timestamp).
- After reset it reads both words, compares them against build-time expected values and drives pass/fail status.
- Once the check completes it shares the sysid slave with a host Avalon-MM slave port (e.g. a debug master) and serializes host reads onto it.

Parameters:
- EXPECTED_ID, 32'd0, value the ID word (address 0) must return.
- EXPECTED_TIMESTAMP, 32'd1523548286, value the timestamp word (address 1) must return.
- READ_LATENCY, 1, cycles from sysid_read assertion to readdata capture; legal range 1..7.
- MAX_RETRY, 3, boot check attempts before declaring failure; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- sysid_address  out  1  word select to sysid slave.
- sysid_read  out  1  read strobe to sysid slave, one cycle per access.
- sysid_readdata  in  32  sysid read data.
- host_address  in  1  host word select.
- host_read  in  1  host read request.
- host_waitrequest  out  1  host stall.
- host_readdata  out  32  host read data.
- host_readdatavalid  out  1  one-cycle host data strobe.
- check_done  out  1  boot check finished (pass or fail).
- check_pass  out  1  ID (and timestamp, see Optional Feature) matched.
- id_word  out  32  captured ID word.
- ts_word  out  32  captured timestamp word.
- retry_count  out  4  attempts consumed.

Behaviour:
- Reset (asynchronous assert, synchronous deassert edge): all outputs 0 except host_waitrequest=1; FSM in BOOT_ID; latency counter 0; retry_count 0.
- FSM states: BOOT_ID, WAIT_ID, BOOT_TS, WAIT_TS, CHECK, READY, HOST_WAIT, FAIL.
- BOOT_ID: sysid_address=0, sysid_read=1 for exactly one cycle, then WAIT_ID.
- WAIT_ID: count READ_LATENCY cycles, counting the read cycle as 1. Capture sysid_readdata into id_word on the cycle the count reaches READ_LATENCY, then go to BOOT_TS.
  - READ_LATENCY=1: capture in the first WAIT_ID cycle, i.e. the data present the cycle after the strobe.
- BOOT_TS / WAIT_TS: same sequence with address 1, capturing into ts_word.
- CHECK: one cycle; retry_count increments.
  - On match: check_pass=1, check_done=1, go to READY.
  - On mismatch with retry_count < MAX_RETRY: go back to BOOT_ID.
  - On mismatch with retry_count reaching MAX_RETRY: check_pass=0, check_done=1, go to FAIL.
- FAIL: terminal until reset. Host port still serviced exactly as in READY, so debug can read the words.
- READY: host_waitrequest=0.
  - On host_read=1: accept the request that cycle, drive sysid_address=host_address and sysid_read=1 for that cycle, raise host_waitrequest the next cycle and go to HOST_WAIT.
- HOST_WAIT: after READ_LATENCY, capture into host_readdata, pulse host_readdatavalid for 1 cycle, drop host_waitrequest and return to READY (or FAIL).
  - Host read-to-valid latency = READ_LATENCY+1 cycles.
- Arbitration rules:
  - Host reads during BOOT_*/WAIT_*/CHECK: held by host_waitrequest=1 and serviced after check_done.
  - At most one sysid access is outstanding at any time.
  - host_read with host_waitrequest=1 is not accepted; the host must hold the request.
- check_pass, check_done, id_word, ts_word hold their values until reset. A failed attempt's words stay visible until overwritten by the retry.
- Reset mid-read: everything returns to reset values, the in-flight capture is dropped, no host_readdatavalid is emitted, and the boot check restarts.
- sysid_read is never asserted in FAIL or READY except for accepted host reads.

Optional Feature:
- Macro SYSID_TIMESTAMP_CHECK_EN.
- Defined: CHECK requires id_word==EXPECTED_ID AND ts_word==EXPECTED_TIMESTAMP.
- Undefined: CHECK compares id_word only. ts_word is still read and captured, and EXPECTED_TIMESTAMP is ignored.
- Sequencing and latency are identical in both builds.

Test Plan:
- Sysid model returns ID=0 and TS=1523548286, READ_LATENCY=1, macro defined -> check_done=1 and check_pass=1 on cycle 5 after reset release; retry_count=1; id_word=0; ts_word=1523548286.
- Model returns ID=0x1234 always, MAX_RETRY=3 -> three full sequences (6 sysid reads), then check_done=1, check_pass=0, retry_count=3; FSM in FAIL and no further sysid_read.
- Model returns TS=0 with correct ID -> macro defined: fail after MAX_RETRY; macro undefined: pass on the first attempt with ts_word=0.
- Host asserts host_read with address 1 at the first cycle after reset -> waitrequest held through boot; after check_done, exactly one host_readdatavalid with host_readdata=1523548286.
- READ_LATENCY=3, back-to-back host reads to addresses 0 and 1 -> each valid appears 4 cycles after acceptance, data 0 then 1523548286; never two outstanding sysid_read.
- reset_n asserted during WAIT_TS -> all outputs return to reset values asynchronously; after release the sequence restarts from BOOT_ID with retry_count=0.
